// File: rtl/sysahb_sram_ctrl.sv
// sysahb_sram_ctrl: zero-wait AHB-Lite slave for the system-bus data RAM.
// A one-entry write buffer lets a data-phase write coexist with a read that owns the RAM port.
module sysahb_sram_ctrl #(
    parameter int AW = 13
) (
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);
    typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_t;
    state_t state_q, state_d;
    logic rd_dp_q, rd_dp_d, wr_dp_q, wr_dp_d, buf_v_q, buf_v_d;
    logic [AW-1:0] dp_addr_q, dp_addr_d, buf_addr_q, buf_addr_d, ram_addr;
    logic [3:0] dp_strb_q, dp_strb_d, buf_strb_q, buf_strb_d, strb, ram_strb;
    logic [31:0] buf_data_q, buf_data_d, ram_wdata, ram_rdata_q;
    logic [31:0] mem [2**AW];
    logic acc, bad, rd_ap, wr_now, load, ram_we, hit;
    logic unused;

    assign unused = ^{hburst, hprot, haddr[31:AW+2]};

    always_comb begin
        acc = hsel & hready_in & htrans[1];
        bad = (hsize > 3'd2) | (hsize == 3'd1 & haddr[0]) | (hsize == 3'd2 & |haddr[1:0]);
        rd_ap = acc & ~bad & ~hwrite;
        wr_now = wr_dp_q & hready_in;
        strb = hsize == 3'd0 ? 4'b0001 << haddr[1:0] :
               hsize == 3'd1 ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        state_d = state_q == S_ERR1 ? S_ERR2 : (acc & bad) ? S_ERR1 : S_OKAY;
        rd_dp_d = hready_in ? rd_ap : rd_dp_q;
        wr_dp_d = hready_in ? acc & ~bad & hwrite : wr_dp_q;
        dp_addr_d = acc ? haddr[AW+1:2] : dp_addr_q;
        dp_strb_d = acc ? strb : dp_strb_q;
        // The read owns the port; a coincident data-phase write parks in the buffer.
        load = rd_ap & wr_now;
        buf_v_d = load | (buf_v_q & (rd_ap | wr_now));
        buf_addr_d = load ? dp_addr_q : buf_addr_q;
        buf_strb_d = load ? dp_strb_q : buf_strb_q;
        buf_data_d = load ? hwdata : buf_data_q;
        ram_we = ~rd_ap & (wr_now | buf_v_q);
        ram_addr = rd_ap ? haddr[AW+1:2] : wr_now ? dp_addr_q : buf_addr_q;
        ram_strb = wr_now ? dp_strb_q : buf_strb_q;
        ram_wdata = wr_now ? hwdata : buf_data_q;
        hit = buf_v_q & (buf_addr_q == dp_addr_q);
        hrdata = '0;
        for (int i = 0; i < 4; i++)
            hrdata[8*i +: 8] = !rd_dp_q ? 8'h00 : (hit & buf_strb_q[i]) ? buf_data_q[8*i +: 8] : ram_rdata_q[8*i +: 8];
        hresp = state_q != S_OKAY;
        hreadyout = state_q != S_ERR1;
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q <= S_OKAY;
            rd_dp_q <= 1'b0;
            wr_dp_q <= 1'b0;
            dp_addr_q <= '0;
            dp_strb_q <= '0;
            buf_v_q <= 1'b0;
            buf_addr_q <= '0;
            buf_strb_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q <= state_d;
            rd_dp_q <= rd_dp_d;
            wr_dp_q <= wr_dp_d;
            dp_addr_q <= dp_addr_d;
            dp_strb_q <= dp_strb_d;
            buf_v_q <= buf_v_d;
            buf_addr_q <= buf_addr_d;
            buf_strb_q <= buf_strb_d;
            buf_data_q <= buf_data_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rd_ap) ram_rdata_q <= mem[ram_addr];
        for (int i = 0; i < 4; i++)
            if (ram_we && ram_strb[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end

    // A write data phase always follows a read-free cycle, so the buffer is free by then.
    assert property (@(posedge sys_clk) disable iff (!sys_resetn) wr_now |-> !buf_v_q);
endmodule

// File: tb/tb_sysahb_sram_ctrl.sv
// tb_sysahb_sram_ctrl: vector table, corner sequences and random traffic against a byte-array model.
module tb_sysahb_sram_ctrl;
    localparam logic [31:0] B = 32'h2000_0000;
    logic sys_clk = 1'b0, sys_resetn = 1'b0;
    logic hsel = 1'b0, hwrite = 1'b0, hready_in = 1'b1;
    logic [1:0] htrans = 2'b00;
    logic [2:0] hsize = 3'd0, hburst = 3'd0;
    logic [3:0] hprot = 4'd0;
    logic [31:0] haddr = '0, hwdata = '0, hrdata;
    logic hreadyout, hresp;

    sysahb_sram_ctrl dut (
        .sys_clk(sys_clk), .sys_resetn(sys_resetn), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hready_in(hready_in), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum logic [2:0] {K_NONE, K_RD, K_WR, K_E1, K_E2} kind_t;
    typedef struct {
        logic sel; logic [1:0] tr; logic wr; logic [2:0] sz;
        logic [31:0] a; logic [31:0] wd; logic err; logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] mem_m [256];
    kind_t dp_kind = K_NONE;
    logic [31:0] dp_addr, dp_wdata, dp_exp;
    logic [2:0] dp_size;
    logic dp_use_exp;
    int checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic is_bad(input logic [2:0] sz, input logic [31:0] a);
        return sz > 3'd2 || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
    endfunction

    task automatic wr_model(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        for (int l = 0; l < 4; l++)
            if (sz == 3'd2 || (sz == 3'd1 && l / 2 == int'(a[1])) || (sz == 3'd0 && l == int'(a[1:0])))
                mem_m[{a[7:2], 2'(l)}] = d[8*l +: 8];
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return {mem_m[{a[7:2], 2'd3}], mem_m[{a[7:2], 2'd2}], mem_m[{a[7:2], 2'd1}], mem_m[{a[7:2], 2'd0}]};
    endfunction

    task automatic cycle(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic bad,
                         input logic use_exp, input logic [31:0] exp_v, input logic force_low);
        logic rdy;
        logic [31:0] e_rd;
        rdy = (dp_kind != K_E1) && !force_low;
        hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a; hready_in = rdy;
        hburst = 3'($urandom); hprot = 4'($urandom);
        hwdata = dp_kind == K_WR ? dp_wdata : $urandom;
        @(negedge sys_clk);
        e_rd = dp_kind == K_RD ? (dp_use_exp ? dp_exp : rd_model(dp_addr)) : 32'h0;
        chk("hreadyout", 32'(hreadyout), 32'(dp_kind != K_E1));
        chk("hresp", 32'(hresp), 32'(dp_kind == K_E1 || dp_kind == K_E2));
        chk("hrdata", hrdata, e_rd);
        if (dp_kind == K_WR && rdy) wr_model(dp_addr, dp_size, dp_wdata);
        if (dp_kind == K_E1) dp_kind = K_E2;
        else if (rdy) begin
            dp_kind = !(sel && tr[1]) ? K_NONE : bad ? K_E1 : wr ? K_WR : K_RD;
            dp_addr = a; dp_size = sz; dp_wdata = wd; dp_use_exp = use_exp; dp_exp = exp_v;
        end
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic add(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic err, input logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd; v.err = err; v.rd = rd;
        tbl.push_back(v);
    endtask

    task automatic add_wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd, input logic err);
        add(1'b1, 2'b10, 1'b1, sz, a, wd, err, 32'h0);
    endtask

    task automatic add_rd(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd, input logic err);
        add(1'b1, 2'b10, 1'b0, sz, a, 32'h0, err, rd);
    endtask

    task automatic add_idle();
        add(1'b1, 2'b00, 1'b0, 3'd2, B, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] up, a;
        logic [2:0] sz;
        logic [1:0] off;
        logic [5:0] w;
        int r;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_hreadyout", 32'(hreadyout), 32'h1);
        chk("rst_hresp", 32'(hresp), 32'h0);
        sys_resetn = 1'b1;

        for (int i = 0; i < 64; i++)
            cycle(1'b1, 2'b10, 1'b1, 3'd2, B + 32'(4 * i), $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b00, 1'b0, 3'd2, B, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        add_wr(3'd2, B + 32'h10, 32'hDEADBEEF, 1'b0);
        add_idle();
        add_rd(3'd2, B + 32'h10, 32'hDEADBEEF, 1'b0);
        add_wr(3'd2, B + 32'h20, 32'h11223344, 1'b0);
        add_idle();
        add_wr(3'd0, B + 32'h21, 32'h0000AA00, 1'b0);
        for (int i = 0; i < 4; i++) add_rd(3'd2, B + 32'h20, 32'h1122AA44, 1'b0);
        add_idle();
        add_rd(3'd2, B + 32'h20, 32'h1122AA44, 1'b0);
        add_rd(3'd0, B + 32'h21, 32'h1122AA44, 1'b0);
        for (int i = 0; i < 8; i++) add_wr(3'd2, B + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0);
        for (int i = 0; i < 8; i++) add_rd(3'd2, B + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0);
        add_wr(3'd2, B + 32'hC0, 32'h12345678, 1'b0);
        add_rd(3'd2, B + 32'h04, 32'hC0DE0001, 1'b0);
        add_wr(3'd2, B + 32'hC4, 32'h9ABCDEF0, 1'b0);
        add_rd(3'd2, B + 32'hC0, 32'h12345678, 1'b0);
        add_idle();
        add_rd(3'd2, B + 32'hC4, 32'h9ABCDEF0, 1'b0);
        add_wr(3'd1, B + 32'h02, 32'hBEEF5555, 1'b0);
        add_idle();
        add_rd(3'd2, B, 32'hBEEF0000, 1'b0);
        add_wr(3'd1, B + 32'h03, 32'hFFFFFFFF, 1'b1);
        add_idle();
        add_idle();
        add_rd(3'd2, B, 32'hBEEF0000, 1'b0);
        add_rd(3'd3, B, 32'h0, 1'b1);
        add_wr(3'd2, B, 32'h77777777, 1'b0);
        add_idle();
        add_rd(3'd2, B, 32'hBEEF0000, 1'b0);
        add_wr(3'd2, B + 32'h06, 32'hFFFFFFFF, 1'b1);
        add_idle();
        add_idle();
        add_rd(3'd2, B + 32'h04, 32'hC0DE0001, 1'b0);
        add(1'b0, 2'b10, 1'b1, 3'd2, B + 32'h04, 32'hFFFFFFFF, 1'b0, 32'h0);
        add_idle();
        add_rd(3'd2, 32'h6000_0004, 32'hC0DE0001, 1'b0);
        add_idle();
        foreach (tbl[i])
            cycle(tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].err, 1'b1, tbl[i].rd, 1'b0);

        cycle(1'b1, 2'b10, 1'b1, 3'd2, B + 32'h40, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b10, 1'b1, 3'd2, B + 32'h44, 32'h44444444, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b00, 1'b0, 3'd2, B, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b10, 1'b1, 3'd2, B + 32'h40, 32'h00000005, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b10, 1'b0, 3'd2, B + 32'h44, 32'h0, 1'b0, 1'b1, 32'h44444444, 1'b0);
        hsel = 1'b0; htrans = 2'b00; hready_in = 1'b1;
        sys_resetn = 1'b0;
        #1;
        chk("mid_rst_hrdata", hrdata, 32'h0);
        chk("mid_rst_hreadyout", 32'(hreadyout), 32'h1);
        chk("mid_rst_hresp", 32'(hresp), 32'h0);
        dp_kind = K_NONE;
        wr_model(B + 32'h40, 3'd2, 32'h0BADF00D);
        @(posedge sys_clk);
        #1;
        sys_resetn = 1'b1;
        cycle(1'b1, 2'b10, 1'b0, 3'd2, B + 32'h40, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
        cycle(1'b1, 2'b00, 1'b0, 3'd2, B, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        repeat (3) cycle(1'b1, 2'b10, 1'b1, 3'd2, B + 32'h80, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 2'b10, 1'b0, 3'd2, B + 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b10, 1'b1, 3'd2, B + 32'h80, 32'h80808080, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b10, 1'b0, 3'd2, B + 32'h80, 32'h0, 1'b0, 1'b1, 32'h80808080, 1'b0);
        cycle(1'b1, 2'b00, 1'b0, 3'd2, B, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            up = $urandom;
            w = 6'($urandom_range(0, 63));
            sz = 3'($urandom_range(0, 2));
            off = sz == 3'd0 ? 2'($urandom_range(0, 3)) : sz == 3'd1 ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            if ($urandom_range(0, 11) == 0) begin
                sz = 3'($urandom_range(0, 3));
                off = 2'($urandom_range(0, 3));
            end
            a = {up[31:15], 7'b0, w, off};
            r = $urandom_range(0, 9);
            cycle(r != 0, r < 2 ? 2'($urandom_range(0, 1)) + (r == 0 ? 2'b10 : 2'b00) : 2'($urandom_range(2, 3)),
                  r >= 6, sz, a, $urandom, is_bad(sz, a), 1'b0, 32'h0,
                  dp_kind == K_NONE && $urandom_range(0, 15) == 0);
        end
        repeat (3) cycle(1'b1, 2'b00, 1'b0, 3'd2, B, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
